// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter: shares the single DDRAM read port between the video
// graphics fetchers (sprite, text tile, BG tile, spare). One read is in flight
// at a time. Each returned 64-bit beat goes back to the requester that owns it.
// A timeout completes the read with an error if DDRAM never answers.
//
// Requester handshake: a requester raises req_valid[i] with req_addr slice i
// and holds both until req_ready[i] pulses for one cycle. The address is
// captured on that pulse. Exactly one rsp_valid[i] pulse follows each
// req_ready[i] pulse. rsp_err qualifies rsp_valid and means the data is invalid.
// On the DDRAM side, a cycle with ddram_rd=1 and ddram_busy=0 is the accepted
// read. A ddram_dout_ready pulse is consumed only while waiting for data.
module pgm_ddram_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 29,
  parameter int DW   = 64,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_urgent,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [DW-1:0]     rsp_data,
  output logic              ddram_rd,
  output logic [AW-1:0]     ddram_addr,
  input  logic              ddram_busy,
  input  logic [DW-1:0]     ddram_dout,
  input  logic              ddram_dout_ready,
  output logic [2:0]        owner,
  output logic              arb_busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Last WAIT count value. No data on this cycle forces the error completion.
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_e          state_q, state_d;
  logic            rd_q, rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      owner_q, owner_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  // Arbitration scratch. owner_q doubles as the round-robin pointer, because it
  // always holds the last granted index.
  logic [7:0]      cand;
  logic [3:0]      idx;
  logic [2:0]      win;
  logic            found;
  logic [AW-1:0]   win_addr;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    logic [NREQ-1:0] m;
    m = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (i == 3'(k)) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Winner selection: urgent-only class if any urgent request is valid,
  // then round-robin from (last grant + 1) mod NREQ.
  always_comb begin
    cand = '0;
    if ((req_valid & req_urgent) != '0) cand[NREQ-1:0] = req_valid & req_urgent;
    else                                cand[NREQ-1:0] = req_valid;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, owner_q} + 4'd1 + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && cand[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  // Address slice of the winning requester.
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) win_addr = req_addr[i*AW +: AW];
    end
  end

  // Next-state and registered-output logic of the IDLE/ISSUE/WAIT machine.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready_d = onehot(win);
          addr_d      = win_addr;
          owner_d     = win;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The strobe rises one cycle after the grant. It stays high (with a
        // stable address) until DDRAM takes it.
        if (!rd_q) begin
          rd_d = 1'b1;
        end else if (!ddram_busy) begin
          rd_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ddram_dout_ready) begin
          rsp_data_d  = ddram_dout;
          rsp_valid_d = onehot(owner_q);
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TMO_LAST) begin
            rsp_valid_d = onehot(owner_q);
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign ddram_rd   = rd_q;
  assign ddram_addr = addr_q;
  assign owner      = owner_q;
  assign arb_busy   = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Bench for pgm_ddram_arbiter. The driver issues transactions and pushes the
// expected grant, DDRAM strobe and response into queues. A negedge monitor pops
// and compares each of them when the DUT presents it.
module tb_pgm_ddram_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 29;
  localparam int DW   = 64;
  localparam int TMO  = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]    req_valid, req_urgent, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic               rsp_err;
  logic [DW-1:0]      rsp_data;
  logic               ddram_rd;
  logic [AW-1:0]      ddram_addr;
  logic               ddram_busy;
  logic [DW-1:0]      ddram_dout;
  logic               ddram_dout_ready;
  logic [2:0]         owner;
  logic               arb_busy;
  logic [1:0]         dbg_state;

  pgm_ddram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_urgent(req_urgent), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .ddram_rd(ddram_rd), .ddram_addr(ddram_addr),
    .ddram_busy(ddram_busy), .ddram_dout(ddram_dout),
    .ddram_dout_ready(ddram_dout_ready), .owner(owner), .arb_busy(arb_busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [2:0] idx; logic [AW-1:0] addr; logic [31:0] cyc; } grant_t;
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] cyc; logic [31:0] len; } rd_t;
  typedef struct packed { logic [2:0] idx; logic err; logic [DW-1:0] data; logic [31:0] cyc; } rsp_t;
  grant_t gnt_q[$];
  rd_t    rdx_q[$];
  rsp_t   rsp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    logic [NREQ-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- reference model ----------------
  logic [NREQ-1:0] pend, urg;
  logic [AW-1:0]   addr_m [NREQ];
  int              last_g;

  // Urgent valid requests outrank the rest. Within the class, the first one
  // after the last grant wins.
  function automatic int pick_winner(input logic [NREQ-1:0] v, input logic [NREQ-1:0] u, input int last);
    logic [NREQ-1:0] cls;
    cls = ((v & u) != '0) ? (v & u) : v;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (cls[j]) return j;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reqs();
    req_valid  = pend;
    req_urgent = urg;
    for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = addr_m[i];
  endtask

  task automatic raise(input int i);
    pend[i]   = 1'b1;
    addr_m[i] = AW'($urandom);
  endtask

  // Applies the current request set in this cycle and plays one full
  // transaction. lat is the number of WAIT cycles before the data arrives.
  // A negative lat, or lat >= TMO, means no data, so a timeout is expected.
  task automatic run_txn(input int busy_len, input int lat, input logic spur, input logic [DW-1:0] data);
    grant_t g;
    rd_t    r;
    rsp_t   s;
    int     c, w, a_cyc, r_cyc, now;
    logic   hit;
    apply_reqs();
    c = cyc;
    w = pick_winner(pend, urg, last_g);
    g.idx = 3'(w); g.addr = addr_m[w]; g.cyc = 32'(c + 1);
    gnt_q.push_back(g);
    r.addr = addr_m[w]; r.cyc = 32'(c + 2); r.len = 32'(busy_len + 1);
    rdx_q.push_back(r);
    a_cyc = c + 2 + busy_len;
    hit   = (lat >= 0) && (lat <= TMO - 1);
    r_cyc = hit ? (a_cyc + 2 + lat) : (a_cyc + 1 + TMO);
    s.idx = 3'(w); s.err = !hit; s.data = hit ? data : '0; s.cyc = 32'(r_cyc);
    rsp_q.push_back(s);
    last_g = w;
    do begin
      tick();
      now = cyc;
      if (now == c + 1) begin
        pend[w]   = 1'b0;
        addr_m[w] = AW'($urandom);
        apply_reqs();
      end
      ddram_busy = (now < a_cyc);
      if (hit && now == a_cyc + 1 + lat) begin
        ddram_dout_ready = 1'b1;
        ddram_dout       = data;
      end else if (spur && now <= c + 2) begin
        ddram_dout_ready = 1'b1;
        ddram_dout       = {$urandom, $urandom};
      end else begin
        ddram_dout_ready = 1'b0;
        ddram_dout       = {$urandom, $urandom};
      end
    end while (now < r_cyc - 1);
    tick();
    ddram_busy       = 1'b0;
    ddram_dout_ready = 1'b0;
  endtask

  task automatic drain();
    while (pend != '0) run_txn($urandom_range(0, 2), $urandom_range(0, 4), 1'b0, {$urandom, $urandom});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({tag, "_rsp_data"},  rsp_data,       64'd0);
    chk({tag, "_ddram_rd"},  64'(ddram_rd),  64'd0);
    chk({tag, "_ddram_addr"}, 64'(ddram_addr), 64'd0);
    chk({tag, "_owner"},     64'(owner),     64'd0);
    chk({tag, "_arb_busy"},  64'(arb_busy),  64'd0);
    chk({tag, "_state"},     64'(dbg_state), 64'd0);
  endtask

  // Grants, lets the read get accepted, then resets in WAIT and sends late
  // data, which must be dropped.
  task automatic reset_in_wait();
    grant_t g;
    rd_t    r;
    int     c, w;
    apply_reqs();
    c = cyc;
    w = pick_winner(pend, urg, last_g);
    g.idx = 3'(w); g.addr = addr_m[w]; g.cyc = 32'(c + 1);
    gnt_q.push_back(g);
    r.addr = addr_m[w]; r.cyc = 32'(c + 2); r.len = 32'd1;
    rdx_q.push_back(r);
    tick();                                   // c+1
    pend[w] = 1'b0; apply_reqs();
    ddram_busy = 1'b0;
    repeat (3) tick();                        // c+4: second WAIT cycle
    reset = 1'b1;
    pend = '0; urg = '0; apply_reqs();
    tick();                                   // c+5: DUT is back in reset state
    reset = 1'b0;
    ddram_dout_ready = 1'b1;
    ddram_dout = {$urandom, $urandom};
    last_g = 0;
    @(negedge clk);
    chk_zero("rst_wait");
    tick();
    ddram_dout_ready = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------- monitor ----------------
  rd_t  rd_cur;
  logic rd_have = 1'b0;
  logic rd_prev = 1'b0;
  int   rd_start = 0;

  always @(negedge clk) begin : monitor
    grant_t g;
    rsp_t   r;
    if (req_ready != '0) begin
      if (gnt_q.size() == 0) chk("grant_unexpected", 64'(req_ready), 64'd0);
      else begin
        g = gnt_q.pop_front();
        chk("grant_onehot", 64'(req_ready), 64'(onehot(g.idx)));
        chk("grant_cycle", 64'(cyc), 64'(g.cyc));
        chk("grant_owner", 64'(owner), 64'(g.idx));
        chk("grant_addr", 64'(ddram_addr), 64'(g.addr));
        chk("grant_busy", 64'(arb_busy), 64'd1);
      end
    end
    if (ddram_rd && !rd_prev) begin
      if (rdx_q.size() == 0) chk("rd_unexpected", 64'(ddram_rd), 64'd0);
      else begin
        rd_cur   = rdx_q.pop_front();
        rd_have  = 1'b1;
        rd_start = cyc;
        chk("rd_start", 64'(cyc), 64'(rd_cur.cyc));
        chk("rd_addr", 64'(ddram_addr), 64'(rd_cur.addr));
      end
    end else if (ddram_rd && rd_have) begin
      chk("rd_addr_stable", 64'(ddram_addr), 64'(rd_cur.addr));
    end
    if (!ddram_rd && rd_prev && rd_have) begin
      chk("rd_len", 64'(cyc - rd_start), 64'(rd_cur.len));
      rd_have = 1'b0;
    end
    rd_prev = ddram_rd;
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_onehot", 64'(rsp_valid), 64'(onehot(r.idx)));
        chk("rsp_err", 64'(rsp_err), 64'(r.err));
        chk("rsp_data", rsp_data, r.data);
        chk("rsp_cycle", 64'(cyc), 64'(r.cyc));
      end
    end else if (rsp_err === 1'b1) begin
      chk("rsp_err_alone", 64'(rsp_err), 64'd0);
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    pend = '0; urg = '0; last_g = 0;
    for (int i = 0; i < NREQ; i++) addr_m[i] = '0;
    req_addr = '0;
    apply_reqs();
    ddram_busy = 1'b0; ddram_dout_ready = 1'b0; ddram_dout = '0;
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // single request, data 5 cycles after the strobe
    pend = 4'b0100; addr_m[2] = 29'h0001234;
    run_txn(0, 4, 1'b0, 64'hDEADBEEF_01234567);

    // round robin with every requester held
    pend = 4'b1000; addr_m[3] = AW'($urandom);
    run_txn(0, 1, 1'b0, {$urandom, $urandom});
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) raise(i);
      run_txn(0, $urandom_range(0, 3), 1'b0, {$urandom, $urandom});
    end
    drain();

    // urgency after last grant 3, then without urgency
    raise(0); raise(1); raise(3); urg = 4'b1000;
    run_txn(0, 2, 1'b0, {$urandom, $urandom});
    raise(3); urg = '0;
    run_txn(0, 2, 1'b0, {$urandom, $urandom});
    drain();

    // busy stall with spurious early data
    raise(0);
    run_txn(7, 3, 1'b1, {$urandom, $urandom});

    // timeout on requester 1 while 0 waits, then 0 is served
    raise(0); raise(1); urg = 4'b0010;
    run_txn(0, -1, 1'b0, {$urandom, $urandom});
    urg = '0;
    run_txn(0, 2, 1'b0, {$urandom, $urandom});

    // data on the last WAIT cycle wins over the timeout
    raise(2);
    run_txn(1, TMO - 1, 1'b0, {$urandom, $urandom});

    // reset while waiting, then service from pointer 0
    raise(2);
    reset_in_wait();
    raise(0); raise(1);
    run_txn(0, 3, 1'b0, {$urandom, $urandom});
    drain();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r, lat;
      if (pend == '0 && $urandom_range(0, 1) == 1) begin
        apply_reqs();
        repeat ($urandom_range(1, 3)) tick();
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) raise(i);
        urg[i] = ($urandom_range(0, 3) == 0);
      end
      if (pend == '0) raise($urandom_range(0, NREQ - 1));
      r   = $urandom_range(0, 19);
      lat = (r == 0) ? -1 : ((r == 1) ? TMO - 1 : $urandom_range(0, 8));
      run_txn($urandom_range(0, 3), lat, ($urandom_range(0, 3) == 0), {$urandom, $urandom});
    end
    urg = '0;
    drain();
    apply_reqs();
    repeat (5) tick();

    chk("grant_left", 64'(gnt_q.size()), 64'd0);
    chk("rd_left", 64'(rdx_q.size()), 64'd0);
    chk("rsp_left", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
